// File: rtl/tdc_interval_calc_pkg.sv
// Shared constants and FSM state encoding for the TDC interval calculator.
package tdc_interval_calc_pkg;

  localparam int NUM_TAPS_DEF   = 36;
  localparam int NUM_DECODE_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_CALC1 = 3'd2,
    ST_CALC2 = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/tdc_interval_calc_event_latch.sv
// Captures one decoder's finished pulse and bin; the first pulse wins until clr.
module tdc_event_latch #(
  parameter int NUM_DECODE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  finished,
  input  logic [NUM_DECODE-1:0] bin,
  output logic                  got,
  output logic [NUM_DECODE-1:0] bin_q
);

  logic                  got_r;
  logic [NUM_DECODE-1:0] bin_r;

  // got flag and bin capture; repeat pulses are ignored once got is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      got_r <= 1'b0;
      bin_r <= '0;
    end else if (clr) begin
      got_r <= 1'b0;
      bin_r <= '0;
    end else if (en && finished && !got_r) begin
      got_r <= 1'b1;
      bin_r <= bin;
    end else begin
      got_r <= got_r;
      bin_r <= bin_r;
    end
  end

  assign got   = got_r;
  assign bin_q = bin_r;

endmodule

// File: rtl/tdc_interval_calc.sv
// Combines start/stop decoder bins with the coarse count into an interval in taps,
// presented on a valid/ready handshake with edge, sign and timeout flags.
module tdc_interval_calc
  import tdc_interval_calc_pkg::*;
#(
  parameter int NUM_TAPS    = NUM_TAPS_DEF,
  parameter int NUM_DECODE  = NUM_DECODE_DEF,
  parameter int COARSE_W    = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_finished,
  input  logic [NUM_DECODE-1:0]          start_bin,
  input  logic                           stop_finished,
  input  logic [NUM_DECODE-1:0]          stop_bin,
  input  logic [COARSE_W-1:0]            coarse_count,
  input  logic                           arm,
  output logic [COARSE_W+NUM_DECODE:0]   result,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic                           err_no_edge,
  output logic                           err_negative,
  output logic                           err_timeout,
  output logic                           busy
);

  localparam int RESULT_W = COARSE_W + NUM_DECODE + 1;
  localparam int RAW_W    = RESULT_W + 1;
  localparam int TMO_W    = $clog2(TIMEOUT_CYC + 1);

  state_e                state_r, state_next_s;
  logic                  got_start_s, got_stop_s;
  logic [NUM_DECODE-1:0] start_bin_q_s, stop_bin_q_s;
  logic                  latch_en_s, latch_clr_s;
  logic                  tmo_hit_s;
  logic [TMO_W-1:0]      tmo_cnt_r;
  logic [COARSE_W-1:0]   coarse_r;
  logic [RESULT_W-1:0]   prod_r;
  logic [RAW_W-1:0]      raw_s;
  logic                  handshake_s;
  logic [RESULT_W-1:0]   result_r;
  logic                  result_valid_r;
  logic                  err_no_edge_r, err_negative_r, err_timeout_r;
  logic                  busy_r;

  assign latch_en_s  = (state_r == ST_WAIT);
  assign latch_clr_s = (state_r == ST_IDLE);
  assign handshake_s = result_valid_r && result_ready;

  tdc_event_latch #(.NUM_DECODE(NUM_DECODE)) u_start_latch (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (latch_en_s),
    .clr      (latch_clr_s),
    .finished (start_finished),
    .bin      (start_bin),
    .got      (got_start_s),
    .bin_q    (start_bin_q_s)
  );

  tdc_event_latch #(.NUM_DECODE(NUM_DECODE)) u_stop_latch (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (latch_en_s),
    .clr      (latch_clr_s),
    .finished (stop_finished),
    .bin      (stop_bin),
    .got      (got_stop_s),
    .bin_q    (stop_bin_q_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; both edges present beats a simultaneous timeout
  always_comb begin
    state_next_s = state_r;
    tmo_hit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (arm) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (got_start_s && got_stop_s) begin
          state_next_s = ST_CALC1;
        end else if ((got_start_s || got_stop_s) &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1))) begin
          state_next_s = ST_DONE;
          tmo_hit_s    = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_CALC1: state_next_s = ST_CALC2;
      ST_CALC2: state_next_s = ST_DONE;
      ST_DONE: begin
        if (handshake_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Timeout counter runs only while exactly one edge has been seen in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= '0;
    end else if (state_r != ST_WAIT) begin
      tmo_cnt_r <= '0;
    end else if (got_start_s || got_stop_s) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Coarse capture on arm and first arithmetic stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coarse_r <= '0;
      prod_r   <= '0;
    end else begin
      if ((state_r == ST_IDLE) && arm) begin
        coarse_r <= coarse_count;
      end else begin
        coarse_r <= coarse_r;
      end
      if (state_r == ST_CALC1) begin
        prod_r <= RESULT_W'(coarse_r) * RESULT_W'(NUM_TAPS);
      end else begin
        prod_r <= prod_r;
      end
    end
  end

  // MSB of raw_s is the sign of the two's-complement interval
  always_comb begin
    raw_s = {1'b0, prod_r} + RAW_W'(start_bin_q_s) - RAW_W'(stop_bin_q_s);
  end

  // Output registers: loaded on timeout or CALC2, held through DONE, cleared on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r       <= '0;
      result_valid_r <= 1'b0;
      err_no_edge_r  <= 1'b0;
      err_negative_r <= 1'b0;
      err_timeout_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_WAIT: begin
          if (tmo_hit_s) begin
            result_r       <= '0;
            result_valid_r <= 1'b1;
            err_no_edge_r  <= 1'b0;
            err_negative_r <= 1'b0;
            err_timeout_r  <= 1'b1;
          end
        end
        ST_CALC2: begin
          result_r       <= raw_s[RAW_W-1] ? '0 : raw_s[RESULT_W-1:0];
          result_valid_r <= 1'b1;
          err_no_edge_r  <= (start_bin_q_s == '0) || (stop_bin_q_s == '0);
          err_negative_r <= raw_s[RAW_W-1];
          err_timeout_r  <= 1'b0;
        end
        ST_DONE: begin
          if (handshake_s) begin
            result_r       <= '0;
            result_valid_r <= 1'b0;
            err_no_edge_r  <= 1'b0;
            err_negative_r <= 1'b0;
            err_timeout_r  <= 1'b0;
          end
        end
        default: begin
          result_r       <= result_r;
          result_valid_r <= result_valid_r;
        end
      endcase
    end
  end

  // busy tracks the state being entered so it is a clean register output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
    end
  end

  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign err_no_edge  = err_no_edge_r;
  assign err_negative = err_negative_r;
  assign err_timeout  = err_timeout_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_tdc_interval_calc.sv
// Self-checking bench for tdc_interval_calc: directed vector table, hand sequences, random vs. model.
module tb_tdc_interval_calc;

  localparam int NT = 36;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_finished, stop_finished, arm, result_ready;
  logic [7:0]  start_bin, stop_bin;
  logic [15:0] coarse_count;
  logic [24:0] result;
  logic        result_valid, err_no_edge, err_negative, err_timeout, busy;

  int checks = 0;
  int errors = 0;

  tdc_interval_calc dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_finished (start_finished),
    .start_bin      (start_bin),
    .stop_finished  (stop_finished),
    .stop_bin       (stop_bin),
    .coarse_count   (coarse_count),
    .arm            (arm),
    .result         (result),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .err_no_edge    (err_no_edge),
    .err_negative   (err_negative),
    .err_timeout    (err_timeout),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] coarse;
    logic [7:0]  sb, pb, dup_bin;
    int          ds, dp, dup;   // pulse edge index after arm; -1/0 = none
    logic [24:0] res;
    logic        en, eneg, eto;
    int          vedge;         // edge index after which result_valid is first seen
    int          hold;          // cycles to hold result_ready low
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    bit seen;
    logic [24:0] held;
    @(posedge clk); #1;
    arm = 1'b1; coarse_count = v.coarse;
    @(posedge clk); #1;
    arm = 1'b0; coarse_count = 16'($urandom);
    k = 0; seen = 1'b0;
    while (!seen && k < 300) begin
      k++;
      start_finished = (k == v.ds) || (k == v.dup);
      start_bin      = (k == v.ds) ? v.sb : ((k == v.dup) ? v.dup_bin : 8'($urandom));
      stop_finished  = (k == v.dp);
      stop_bin       = (k == v.dp) ? v.pb : 8'($urandom);
      @(posedge clk); #1;
      start_finished = 1'b0; stop_finished = 1'b0;
      seen = result_valid;
    end
    check({v.name, " valid_edge"}, k, v.vedge);
    check({v.name, " result"}, result, v.res);
    check({v.name, " err_no_edge"}, err_no_edge, v.en);
    check({v.name, " err_negative"}, err_negative, v.eneg);
    check({v.name, " err_timeout"}, err_timeout, v.eto);
    check({v.name, " busy"}, busy, 1);
    held = result;
    for (int h = 0; h < v.hold; h++) begin
      arm            = (h == 2);
      coarse_count   = 16'($urandom);
      start_finished = (h == 4);
      stop_finished  = (h == 5);
      @(posedge clk); #1;
      arm = 1'b0; start_finished = 1'b0; stop_finished = 1'b0;
      check({v.name, " hold_valid"}, result_valid, 1);
      check({v.name, " hold_result"}, result, held);
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check({v.name, " post_valid"}, result_valid, 0);
    check({v.name, " post_busy"}, busy, 0);
    check({v.name, " post_errs"}, {err_no_edge, err_negative, err_timeout}, 0);
    if (v.hold > 0) begin
      repeat (3) @(posedge clk);
      #1;
      check({v.name, " arm_ignored"}, {busy, result_valid}, 0);
    end
  endtask

  vec_t tbl[11];
  vec_t rv;
  longint raw;

  initial begin
    rst_n = 1'b0; arm = 1'b0; start_finished = 1'b0; stop_finished = 1'b0;
    start_bin = 8'd0; stop_bin = 8'd0; coarse_count = 16'd0; result_ready = 1'b0;

    tbl[0]  = '{"basic",      16'd3,     8'd10,  8'd4, 8'd0,  1,  3, 0, 25'd114,     1'b0, 1'b0, 1'b0, 6,  10};
    tbl[1]  = '{"stop_first", 16'd1,     8'd20,  8'd5, 8'd0,  3,  1, 0, 25'd51,      1'b0, 1'b0, 1'b0, 6,  0};
    tbl[2]  = '{"same_cycle", 16'd1,     8'd20,  8'd5, 8'd0,  2,  2, 0, 25'd51,      1'b0, 1'b0, 1'b0, 5,  0};
    tbl[3]  = '{"negative",   16'd0,     8'd3,   8'd9, 8'd0,  1,  1, 0, 25'd0,       1'b0, 1'b1, 1'b0, 4,  0};
    tbl[4]  = '{"no_edge",    16'd2,     8'd0,   8'd7, 8'd0,  1,  2, 0, 25'd65,      1'b1, 1'b0, 1'b0, 5,  0};
    tbl[5]  = '{"timeout",    16'd5,     8'd12,  8'd3, 8'd0,  2, -1, 0, 25'd0,       1'b0, 1'b0, 1'b1, 66, 0};
    tbl[6]  = '{"dup_start",  16'd4,     8'd30,  8'd6, 8'd99, 1,  4, 2, 25'd168,     1'b0, 1'b0, 1'b0, 7,  0};
    tbl[7]  = '{"max_coarse", 16'hFFFF,  8'd255, 8'd1, 8'd0,  1,  1, 0, 25'd2359514, 1'b0, 1'b0, 1'b0, 4,  0};
    tbl[8]  = '{"zero_raw",   16'd0,     8'd5,   8'd5, 8'd0,  1,  2, 0, 25'd0,       1'b0, 1'b0, 1'b0, 5,  0};
    tbl[9]  = '{"both_zero",  16'd1,     8'd0,   8'd0, 8'd0,  2,  1, 0, 25'd36,      1'b1, 1'b0, 1'b0, 5,  0};
    tbl[10] = '{"late_stop",  16'd7,     8'd40,  8'd2, 8'd0,  1, 65, 0, 25'd0,       1'b0, 1'b0, 1'b1, 65, 0};

    #12;
    check("reset_outputs", {result, result_valid, err_no_edge, err_negative, err_timeout, busy}, 0);
    @(negedge clk); rst_n = 1'b1;

    // pulses while IDLE must not start anything
    @(posedge clk); #1;
    start_finished = 1'b1; stop_finished = 1'b1; start_bin = 8'd9; stop_bin = 8'd1;
    @(posedge clk); #1;
    start_finished = 1'b0; stop_finished = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ignores_pulses", {busy, result_valid}, 0);

    for (int i = 0; i < 11; i++) run_vec(tbl[i]);

    // reset asserted while in CALC1
    @(posedge clk); #1;
    arm = 1'b1; coarse_count = 16'd9;
    @(posedge clk); #1;
    arm = 1'b0;
    start_finished = 1'b1; stop_finished = 1'b1; start_bin = 8'd3; stop_bin = 8'd2;
    @(posedge clk); #1;
    start_finished = 1'b0; stop_finished = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {result, result_valid, err_no_edge, err_negative, err_timeout, busy}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_idle", {busy, result_valid}, 0);

    // randomized vectors against an arithmetic model
    for (int i = 0; i < 30; i++) begin
      rv.name   = "rand";
      rv.coarse = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
      rv.sb     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      rv.pb     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      rv.dup_bin = 8'd0;
      rv.ds     = $urandom_range(1, 12);
      rv.dp     = $urandom_range(1, 12);
      rv.dup    = 0;
      raw       = longint'(rv.coarse) * NT + longint'(rv.sb) - longint'(rv.pb);
      rv.res    = (raw < 0) ? 25'd0 : 25'(raw);
      rv.eneg   = (raw < 0);
      rv.en     = (rv.sb == 8'd0) || (rv.pb == 8'd0);
      rv.eto    = 1'b0;
      rv.vedge  = ((rv.ds > rv.dp) ? rv.ds : rv.dp) + 3;
      rv.hold   = $urandom_range(0, 2);
      run_vec(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
